// File: rtl/read_command_scoreboard_if.sv
// Read-command push, write-snoop and head/status signals of the read command scoreboard.
// master drives pushes, write snoops and pops; slave is the scoreboard itself.
interface read_command_scoreboard_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter int TID_W  = 2
);
  logic                     rstrobe;
  logic [ADDR_W-1:0]        raddr;
  logic [TID_W-1:0]         rtid;
  logic [1:0]               rsize;
  logic                     wready;
  logic [ADDR_W-1:0]        waddr;
  logic [TID_W-1:0]         wtid;
  logic [1:0]               wsize;
  logic                     wcommit;
  logic                     pop;
  logic                     head_valid;
  logic [ADDR_W-1:0]        head_addr;
  logic [TID_W-1:0]         head_tid;
  logic [1:0]               head_size;
  logic [$clog2(DEPTH):0]   count;
  logic                     full;
  logic                     empty;
  logic                     stall;
  logic                     rerr;
  logic [TID_W-1:0]         rerr_tid;

  modport master (
    output rstrobe, raddr, rtid, rsize, wready, waddr, wtid, wsize, wcommit, pop,
    input  head_valid, head_addr, head_tid, head_size, count, full, empty, stall, rerr, rerr_tid
  );

  modport slave (
    input  rstrobe, raddr, rtid, rsize, wready, waddr, wtid, wsize, wcommit, pop,
    output head_valid, head_addr, head_tid, head_size, count, full, empty, stall, rerr, rerr_tid
  );
endinterface

// File: rtl/read_command_scoreboard.sv
// In-order read-command FIFO that holds back its head while a snooped write overlaps it; push visible 1 cycle later,
// pops only when head is hazard-free, pushes to a full FIFO are dropped with rerr. READ_COMMAND_SCOREBOARD_TID_MATCH_EN adds TID qualification.
module read_command_scoreboard #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter int TID_W  = 2
) (
  input logic                    clk,
  input logic                    rst,
  read_command_scoreboard_if.slave sb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [TID_W-1:0]  tid_q  [DEPTH];
  logic [1:0]        size_q [DEPTH];
  logic [DEPTH-1:0]  haz_q;
  logic [DEPTH-1:0]  haz_next;
  logic [DEPTH-1:0]  hit;
  logic              push_hit;
  logic [PTR_W-1:0]  rptr;
  logic [PTR_W-1:0]  wptr;
  logic [CNT_W-1:0]  cnt;
  logic              rerr_q;
  logic [TID_W-1:0]  rerr_tid_q;
  logic              empty;
  logic              full;
  logic              head_valid;
  logic              pop_acc;
  logic              push_acc;
  logic              drop;

  // Ranges are aligned to their burst size, so lo|span never wraps past the top of the address space.
  function automatic logic overlaps(input logic [ADDR_W-1:0] a0, input logic [1:0] s0,
                                    input logic [ADDR_W-1:0] a1, input logic [1:0] s1);
    logic [ADDR_W-1:0] span0, span1, lo0, lo1, hi0, hi1;
    span0 = (ADDR_W'(1) << s0) - ADDR_W'(1);
    span1 = (ADDR_W'(1) << s1) - ADDR_W'(1);
    lo0   = a0 & ~span0;
    lo1   = a1 & ~span1;
    hi0   = lo0 | span0;
    hi1   = lo1 | span1;
    return (lo0 <= hi1) && (lo1 <= hi0);
  endfunction

  assign empty      = (cnt == '0);
  assign full       = (cnt == CNT_W'(DEPTH));
  assign head_valid = !empty && !haz_q[rptr];
  assign pop_acc    = sb.pop && head_valid;
  assign push_acc   = sb.rstrobe && (!full || pop_acc);
  assign drop       = sb.rstrobe && !push_acc;

`ifdef READ_COMMAND_SCOREBOARD_TID_MATCH_EN
  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = sb.wready && (sb.wtid == tid_q[i]) &&
               overlaps(sb.waddr, sb.wsize, addr_q[i], size_q[i]);
    end
    push_hit = sb.wready && (sb.wtid == sb.rtid) &&
               overlaps(sb.waddr, sb.wsize, sb.raddr, sb.rsize);
  end
`else
  logic unused_wtid;
  assign unused_wtid = ^sb.wtid;

  always_comb begin
    hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      hit[i] = sb.wready && overlaps(sb.waddr, sb.wsize, addr_q[i], size_q[i]);
    end
    push_hit = sb.wready && overlaps(sb.waddr, sb.wsize, sb.raddr, sb.rsize);
  end
`endif

  // A fresh hazard outranks a same-cycle commit; the slot being written takes the push's own hazard.
  always_comb begin
    haz_next = hit | (haz_q & ~{DEPTH{sb.wcommit}});
    if (push_acc) begin
      haz_next[wptr] = push_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      addr_q[wptr] <= sb.raddr;
      tid_q[wptr]  <= sb.rtid;
      size_q[wptr] <= sb.rsize;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr       <= '0;
      wptr       <= '0;
      cnt        <= '0;
      haz_q      <= '0;
      rerr_q     <= 1'b0;
      rerr_tid_q <= '0;
    end else begin
      haz_q  <= haz_next;
      rerr_q <= drop;
      if (drop) begin
        rerr_tid_q <= sb.rtid;
      end
      if (push_acc) begin
        wptr <= wptr + PTR_W'(1);
      end
      if (pop_acc) begin
        rptr <= rptr + PTR_W'(1);
      end
      if (push_acc && !pop_acc) begin
        cnt <= cnt + CNT_W'(1);
      end else if (pop_acc && !push_acc) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign sb.head_valid = head_valid;
  assign sb.stall      = !empty && haz_q[rptr];
  assign sb.head_addr  = empty ? '0 : addr_q[rptr];
  assign sb.head_tid   = empty ? '0 : tid_q[rptr];
  assign sb.head_size  = empty ? '0 : size_q[rptr];
  assign sb.count      = cnt;
  assign sb.full       = full;
  assign sb.empty      = empty;
  assign sb.rerr       = rerr_q;
  assign sb.rerr_tid   = rerr_tid_q;

endmodule

// File: tb/tb_read_command_scoreboard.sv
// Directed plus random stimulus for read_command_scoreboard against a queue-based reference model.
module tb_read_command_scoreboard;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 8;
  localparam int TID_W  = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  read_command_scoreboard_if #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TID_W(TID_W)) sb ();
  read_command_scoreboard #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .TID_W(TID_W)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  typedef struct {
    int addr;
    int tid;
    int size;
    bit haz;
  } ent_t;

  ent_t q[$];
  bit   m_rerr;
  int   m_rerr_tid;
  int   tests;
  int   fails;

  // Ranges from the rule base = addr rounded down to a multiple of the beat count.
  function automatic bit ovl(int a0, int s0, int a1, int s1);
    int n0 = 1 << s0;
    int n1 = 1 << s1;
    int b0 = (a0 / n0) * n0;
    int b1 = (a1 / n1) * n1;
    return (b0 <= b1 + n1 - 1) && (b1 <= b0 + n0 - 1);
  endfunction

  function automatic bit wr_hits(int a, int s, int t);
    bit tid_ok = 1'b1;
`ifdef READ_COMMAND_SCOREBOARD_TID_MATCH_EN
    tid_ok = (int'(sb.wtid) == t);
`else
    tid_ok = (t >= 0);
`endif
    return sb.wready && tid_ok && ovl(int'(sb.waddr), int'(sb.wsize), a, s);
  endfunction

  task automatic model_step();
    bit   hv, pa, pu;
    ent_t e;
    if (rst) begin
      q.delete();
      m_rerr     = 1'b0;
      m_rerr_tid = 0;
      return;
    end
    hv = (q.size() > 0) && !q[0].haz;
    pa = sb.pop && hv;
    pu = sb.rstrobe && ((q.size() < DEPTH) || pa);
    foreach (q[i]) begin
      if (wr_hits(q[i].addr, q[i].size, q[i].tid)) q[i].haz = 1'b1;
      else if (sb.wcommit) q[i].haz = 1'b0;
    end
    e.addr = int'(sb.raddr);
    e.tid  = int'(sb.rtid);
    e.size = int'(sb.rsize);
    e.haz  = wr_hits(e.addr, e.size, e.tid);
    if (pa) void'(q.pop_front());
    if (pu) q.push_back(e);
    m_rerr = sb.rstrobe && !pu;
    if (m_rerr) m_rerr_tid = int'(sb.rtid);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    bit ne = (q.size() > 0);
    check({tag, ".count"}, 32'(sb.count), q.size());
    check({tag, ".empty"}, 32'(sb.empty), !ne);
    check({tag, ".full"}, 32'(sb.full), q.size() == DEPTH);
    check({tag, ".head_valid"}, 32'(sb.head_valid), ne && !q[0].haz);
    check({tag, ".stall"}, 32'(sb.stall), ne && q[0].haz);
    check({tag, ".head_addr"}, 32'(sb.head_addr), ne ? q[0].addr : 0);
    check({tag, ".head_tid"}, 32'(sb.head_tid), ne ? q[0].tid : 0);
    check({tag, ".head_size"}, 32'(sb.head_size), ne ? q[0].size : 0);
    check({tag, ".rerr"}, 32'(sb.rerr), m_rerr);
    check({tag, ".rerr_tid"}, 32'(sb.rerr_tid), m_rerr_tid);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    rst        = 1'b0;
    sb.rstrobe = 1'b0;
    sb.raddr   = '0;
    sb.rtid    = '0;
    sb.rsize   = '0;
    sb.wready  = 1'b0;
    sb.waddr   = '0;
    sb.wtid    = '0;
    sb.wsize   = '0;
    sb.wcommit = 1'b0;
    sb.pop     = 1'b0;
  endtask

  task automatic push(input int a, input int t, input int s);
    sb.rstrobe = 1'b1;
    sb.raddr   = ADDR_W'(a);
    sb.rtid    = TID_W'(t);
    sb.rsize   = 2'(s);
  endtask

  task automatic write(input int a, input int t, input int s);
    sb.wready = 1'b1;
    sb.waddr  = ADDR_W'(a);
    sb.wtid   = TID_W'(t);
    sb.wsize  = 2'(s);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    q.delete();
    m_rerr     = 1'b0;
    m_rerr_tid = 0;
    idle();
    rst = 1'b1;
    tick("reset");
    check("reset.empty_const", 32'(sb.empty), 1);
    check("reset.hv_const", 32'(sb.head_valid), 0);
    idle();

    // Basic in-order FIFO
    push('h20, 0, 0); tick("fifo.push0");
    push('h07, 0, 0); tick("fifo.push1");
    push('h16, 0, 0); tick("fifo.push2");
    idle();
    check("fifo.count3", 32'(sb.count), 3);
    sb.pop = 1'b1;
    check("fifo.head0", 32'(sb.head_addr), 'h20); tick("fifo.pop0");
    check("fifo.head1", 32'(sb.head_addr), 'h07); tick("fifo.pop1");
    check("fifo.head2", 32'(sb.head_addr), 'h16); tick("fifo.pop2");
    idle();
    check("fifo.count0", 32'(sb.count), 0);
    check("fifo.empty", 32'(sb.empty), 1);

    // Overlap then release by commit
    push('h70, 0, 3); tick("ovl.push");
    idle(); write('h77, 0, 0); tick("ovl.write");
    idle();
    check("ovl.stall", 32'(sb.stall), 1);
    check("ovl.hv", 32'(sb.head_valid), 0);
    sb.wcommit = 1'b1; tick("ovl.commit");
    idle();
    check("ovl.release_hv", 32'(sb.head_valid), 1);
    sb.pop = 1'b1; tick("ovl.pop");
    idle();

    // Adjacent, non-overlapping write
    push('h40, 0, 2); tick("novl.push");
    idle(); write('h44, 0, 0); tick("novl.write");
    idle();
    check("novl.stall", 32'(sb.stall), 0);
    check("novl.hv", 32'(sb.head_valid), 1);
    sb.pop = 1'b1; tick("novl.pop");
    idle();

    // TID qualification
    push('h20, 0, 0); tick("tid.push");
    idle(); write('h20, 1, 0); tick("tid.write");
    idle();
`ifdef READ_COMMAND_SCOREBOARD_TID_MATCH_EN
    check("tid.stall", 32'(sb.stall), 0);
`else
    check("tid.stall", 32'(sb.stall), 1);
`endif
    sb.wcommit = 1'b1; tick("tid.commit");
    idle(); sb.pop = 1'b1; tick("tid.pop");
    idle();

    // Overflow and full push+pop
    rst = 1'b1; tick("ovf.reset");
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      push(i * 16, 0, 0);
      tick("ovf.fill");
    end
    check("ovf.full", 32'(sb.full), 1);
    push('h99, 2, 0); tick("ovf.drop");
    check("ovf.rerr", 32'(sb.rerr), 1);
    check("ovf.rerr_tid", 32'(sb.rerr_tid), 2);
    check("ovf.count", 32'(sb.count), 8);
    idle(); tick("ovf.after");
    check("ovf.rerr_pulse", 32'(sb.rerr), 0);
    check("ovf.rerr_tid_hold", 32'(sb.rerr_tid), 2);
    push('hA0, 1, 1); sb.pop = 1'b1; tick("ovf.pushpop");
    idle();
    check("ovf.count_pp", 32'(sb.count), 8);
    check("ovf.rerr_pp", 32'(sb.rerr), 0);

    // Reset mid-operation with a hazarded head
    rst = 1'b1; tick("rmid.reset0");
    idle();
    for (int i = 0; i < 5; i++) begin
      push(i * 16, 0, 0);
      tick("rmid.fill");
    end
    idle(); write('h00, 0, 0); tick("rmid.write");
    check("rmid.stall_before", 32'(sb.stall), 1);
    idle(); rst = 1'b1; push('h55, 1, 0); sb.pop = 1'b1; write('h55, 1, 0);
    tick("rmid.reset");
    idle();
    check("rmid.count", 32'(sb.count), 0);
    check("rmid.empty", 32'(sb.empty), 1);
    check("rmid.stall", 32'(sb.stall), 0);
    push('h33, 3, 1); tick("rmid.push");
    idle();
    check("rmid.visible", 32'(sb.head_valid), 1);
    check("rmid.head", 32'(sb.head_addr), 'h33);

    // Randomized traffic against the model
    for (int c = 0; c < 800; c++) begin
      idle();
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) push($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) write($urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 3));
      sb.wcommit = ($urandom_range(0, 5) == 0);
      sb.pop     = ($urandom_range(0, 2) != 0);
      tick("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/read_command_scoreboard.md
READ_COMMAND_SCOREBOARD -- requirements
Module: read_command_scoreboard

Interface
REQ-001 SHALL have parameter DEPTH, default 8: number of read-command entries; power of two, minimum 2.
REQ-002 SHALL have parameter ADDR_W, default 8: address width in bits.
REQ-003 SHALL have parameter TID_W, default 2: transaction-ID width in bits.
REQ-004 SHALL have one clock and one reset: reset is synchronous and active-high. The ports are named as the codebase does: clk for the clock, and rst for the reset, since the reset is active-high.
REQ-005 Port clk: input, 1 bit, rising-edge clock.
REQ-006 Port rst: input, 1 bit, synchronous active-high reset.
REQ-007 Port rstrobe: input, 1 bit, push request for a read command.
REQ-008 Port raddr: input, ADDR_W bits, read start address.
REQ-009 Port rtid: input, TID_W bits, read transaction ID.
REQ-010 Port rsize: input, 2 bits, read burst code; burst length in beats = 1<<rsize.
REQ-011 Port wready: input, 1 bit, a write is accepted this cycle.
REQ-012 Port waddr: input, ADDR_W bits, address of the accepted write.
REQ-013 Port wtid: input, TID_W bits, ID of the accepted write.
REQ-014 Port wsize: input, 2 bits, burst code of the accepted write.
REQ-015 Port wcommit: input, 1 bit, all accepted writes are committed to memory.
REQ-016 Port pop: input, 1 bit, issue the head command.
REQ-017 Port head_valid: output, 1 bit, the head entry exists and is hazard-free.
REQ-018 Port head_addr, head_tid, head_size: outputs, ADDR_W, TID_W and 2 bits, the head entry fields.
REQ-019 Port count: output, clog2(DEPTH)+1 bits, current occupancy.
REQ-020 Ports full and empty: outputs, 1 bit each, occupancy flags.
REQ-021 Port stall: output, 1 bit, the head entry exists but is blocked by a hazard.
REQ-022 Port rerr: output, 1 bit, one-cycle pulse when a push is dropped.
REQ-023 Port rerr_tid: output, TID_W bits, TID of the dropped push; holds its value until the next drop.

Function
REQ-024 SHALL be an in-order circular FIFO of DEPTH entries; each entry stores addr, tid, size and a hazard bit.
REQ-025 SHALL accept a push when rstrobe=1 and either not full, or pop is accepted in the same cycle.
REQ-026 SHALL drop a push when rstrobe=1 and full with no accepted pop; the same cycle it SHALL set rerr=1 and rerr_tid=rtid.
REQ-027 SHALL accept a pop only when pop=1 and head_valid=1; any other pop SHALL be ignored with no state change.
REQ-028 SHALL make a pushed entry visible at the head no earlier than the next cycle; pushing into an empty FIFO gives head_valid at cycle N+1 at the earliest.
REQ-029 SHALL derive each address range by aligning down: base = addr & ~(beats-1), range = [base, base+beats-1].
REQ-030 SHALL do all range arithmetic in ADDR_W bits, with no wrap past 2^ADDR_W-1; this is guaranteed by the alignment.
REQ-031 SHALL detect a hazard when, with wready=1, the write range overlaps a stored entry's range, or the range of the entry being pushed that cycle.
REQ-032 SHALL set the hazard bit of every matching entry on the next edge.
REQ-033 SHALL clear the hazard bits of all entries on wcommit=1.
REQ-034 When a hazard is detected and wcommit=1 in the same cycle, setting the hazard bit SHALL win over clearing it.
REQ-035 SHALL drive head_valid = !empty && !head.hazard and stall = !empty && head.hazard.
REQ-036 SHALL derive head_addr, head_tid and head_size combinationally from the head entry; they are 0 when empty.
REQ-037 SHALL update count by +1 on push only, -1 on pop only, and 0 on push and pop in the same cycle.
REQ-038 SHALL wrap the read and write pointers modulo DEPTH.
REQ-039 SHALL limit rerr to a single-cycle pulse with no sticky state.

Reset
REQ-040 On rst=1 at a clock edge, pointers, count, all hazard bits, rerr and rerr_tid SHALL become 0.
REQ-041 After reset, empty=1, full=0, head_valid=0 and stall=0.
REQ-042 Reset SHALL take priority over a simultaneous push, pop or wready; a reset mid-operation discards all entries.

Configuration
REQ-043 SHALL support the macro READ_COMMAND_SCOREBOARD_TID_MATCH_EN, which compiles in TID-qualified hazard detection.
REQ-044 With READ_COMMAND_SCOREBOARD_TID_MATCH_EN defined, a hazard SHALL additionally require wtid to equal the entry tid.
REQ-045 Without READ_COMMAND_SCOREBOARD_TID_MATCH_EN, range overlap alone SHALL flag a hazard, and the wtid port SHALL be present but unused.

Verification
REQ-046 Reset and basic FIFO: push 0x20/tid0, 0x07/tid0, 0x16/tid0, all rsize=0, then pop three times -> heads 0x20, 0x07, 0x16 in order; count goes 3 to 0; empty=1.
REQ-047 Overlap and release: push 0x70 rsize=3; write waddr=0x77, wsize=0 -> stall=1 and head_valid=0; then wcommit -> head_valid=1 on the next cycle.
REQ-048 No overlap: push 0x40 rsize=2; write 0x44, wsize=0 -> no hazard and head_valid=1.
REQ-049 TID qualification: push 0x20/tid0; write 0x20/tid1 -> stall=0 with the macro defined and stall=1 with it undefined.
REQ-050 Overflow: push 8 entries plus a 9th with tid2 while not popping -> rerr is a one-cycle pulse, rerr_tid=2, count stays 8; push and pop in the same cycle while full -> accepted, count stays 8.
REQ-051 Reset while holding 5 entries, one of them hazarded -> next cycle count=0, empty=1, stall=0; a subsequent push is visible one cycle later.
